// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx_8bit among NUM_REQ byte streams.
// Optionally locks the grant for a whole packet, and drops a byte if the transmitter never goes busy.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int ID_W          = 2,
    parameter bit LOCK_PACKETS  = 1'b1,
    parameter int START_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic [ID_W-1:0]      grant_id,
    output logic                 locked,
    output logic                 err_timeout
);
    localparam int CNT_W = $clog2(START_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [ID_W-1:0]    rr_r;
    logic [ID_W-1:0]    grant_r;
    logic [ID_W-1:0]    win_idx_s;
    logic [ID_W-1:0]    scan_idx_s;
    logic               locked_r;
    logic               last_r;
    logic               tx_start_r;
    logic               err_r;
    logic [7:0]         tx_data_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [NUM_REQ-1:0] cand_s;
    logic               win_found_s;
    logic               accept_s;
    logic               timeout_s;
    logic               done_s;

    // Candidate set: only the owner while a packet is in progress.
    always_comb begin
        if (locked_r) begin
            cand_s = req_valid & (NUM_REQ'(1'b1) << grant_r);
        end else begin
            cand_s = req_valid;
        end
    end

    // Round-robin search starting just after the pointer.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        scan_idx_s  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx_s = ID_W'((int'(rr_r) + k) % NUM_REQ);
            if (!win_found_s && cand_s[scan_idx_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = scan_idx_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Next-state and per-cycle strobes.
    always_comb begin
        state_s   = state_r;
        accept_s  = 1'b0;
        timeout_s = 1'b0;
        done_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (rst_n && !tx_busy && win_found_s) begin
                    accept_s = 1'b1;
                    state_s  = WAIT_BUSY;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_s = WAIT_DONE;
                end else if (cnt_r == CNT_LAST) begin
                    timeout_s = 1'b1;
                    state_s   = IDLE;
                end else begin
                    state_s = WAIT_BUSY;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    done_s  = 1'b1;
                    state_s = IDLE;
                end else begin
                    state_s = WAIT_DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Ready is a one-hot strobe in the accept cycle only.
    always_comb begin
        if (accept_s) begin
            req_ready = NUM_REQ'(1'b1) << win_idx_s;
        end else begin
            req_ready = '0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath, grant bookkeeping and end-of-byte lock/pointer update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_start_r <= 1'b0;
            err_r      <= 1'b0;
            tx_data_r  <= 8'h00;
            grant_r    <= '0;
            last_r     <= 1'b0;
            locked_r   <= 1'b0;
            rr_r       <= ID_W'(NUM_REQ - 1);
            cnt_r      <= '0;
        end else begin
            tx_start_r <= accept_s;
            err_r      <= timeout_s;
            if (accept_s) begin
                tx_data_r <= req_data[{win_idx_s, 3'b000} +: 8];
                grant_r   <= win_idx_s;
                last_r    <= req_last[win_idx_s];
            end else begin
                tx_data_r <= tx_data_r;
            end
            if (state_r == WAIT_BUSY && !tx_busy && !timeout_s) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= '0;
            end
            // An aborted byte closes out exactly like a transmitted one.
            if (timeout_s || done_s) begin
                if (LOCK_PACKETS && !last_r) begin
                    locked_r <= 1'b1;
                end else begin
                    locked_r <= 1'b0;
                    rr_r     <= grant_r;
                end
            end else begin
                locked_r <= locked_r;
            end
        end
    end

    assign tx_start    = tx_start_r;
    assign tx_data     = tx_data_r;
    assign grant_id    = grant_r;
    assign locked      = locked_r;
    assign err_timeout = err_r;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queued requesters and a randomized transmitter stub,
// checked each cycle against a transaction-level arbitration model plus literal byte sequences.
module tb_uart_tx_arbiter;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_last = '0;
    logic [N-1:0]   req_ready;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           tx_busy = 1'b0;
    logic [1:0]     grant_id;
    logic           locked;
    logic           err_timeout;

    always #5 clk = ~clk;

    uart_tx_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy), .grant_id(grant_id), .locked(locked), .err_timeout(err_timeout)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state (owned by the compare process)
    int         m_rr, m_grant, m_wcnt;
    bit         m_locked, m_last, m_inflight, m_busy_seen;
    bit         e_start, e_err;
    logic [7:0] e_data;
    // Observations shared with the stimulus side
    logic [N-1:0] acc_mask = '0;
    bit           start_seen = 0;
    logic [7:0]   log_q[$];
    int           cyc = 0, t_start = 0, gap = 0, n_err = 0;

    task end_byte();
        m_inflight = 0;
        if (m_last) begin
            m_locked = 0;
            m_rr     = m_grant;
        end else begin
            m_locked = 1;
        end
    endtask

    // Compare process: check outputs, then advance the model across the coming edge.
    always @(negedge clk) begin
        logic [N-1:0] cand, e_ready;
        int win, best, d;
        cyc++;
        if (!rst_n) begin
            m_rr = N - 1; m_grant = 0; m_locked = 0; m_last = 0;
            m_inflight = 0; m_busy_seen = 0; m_wcnt = 0;
            e_start = 0; e_err = 0; e_data = 8'h00;
        end
        cand = m_locked ? (req_valid & (4'b0001 << m_grant)) : req_valid;
        win = -1; best = N;
        for (int i = 0; i < N; i++) begin
            if (cand[i]) begin
                d = (i - m_rr - 1 + 2 * N) % N;
                if (d < best) begin best = d; win = i; end
            end
        end
        e_ready = (rst_n && !m_inflight && !tx_busy && win >= 0) ? (4'b0001 << win) : 4'b0000;
        check("req_ready", req_ready, e_ready);
        check("tx_start", tx_start, e_start);
        check("tx_data", tx_data, e_data);
        check("grant_id", grant_id, m_grant);
        check("locked", locked, m_locked);
        check("err_timeout", err_timeout, e_err);
        if (tx_start) begin log_q.push_back(tx_data); t_start = cyc; end
        if (err_timeout) begin n_err++; gap = cyc - t_start; end
        acc_mask   = req_valid & req_ready;
        start_seen = tx_start;
        e_start = 0; e_err = 0;
        if (rst_n) begin
            if (!m_inflight) begin
                if (e_ready != 4'b0000) begin
                    m_inflight = 1; m_busy_seen = 0; m_wcnt = 0; e_start = 1;
                    e_data = req_data[8*win +: 8]; m_grant = win; m_last = req_last[win];
                end
            end else if (!m_busy_seen) begin
                if (tx_busy) m_busy_seen = 1;
                else begin
                    m_wcnt++;
                    if (m_wcnt == 64) begin e_err = 1; end_byte(); end
                end
            end else if (!tx_busy) begin
                end_byte();
            end
        end
    end

    // Stimulus side: requester queues {last, byte} and transmitter stub
    logic [8:0]   q[N][$];
    logic [N-1:0] hold = '0;
    bit           stub_dead = 0, ext_busy = 0;
    int           rise_in = -1, busy_cnt = 0;

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (q[i].size() > 0) begin
                req_data[8*i +: 8] = q[i][0][7:0];
                req_last[i]        = q[i][0][8];
                req_valid[i]       = !hold[i];
            end else begin
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
                req_valid[i]       = 1'b0;
            end
        end
    endtask

    task automatic push(input int r, input logic [7:0] b, input logic l);
        q[r].push_back({l, b});
    endtask

    task automatic tick();
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) begin
            if (acc_mask[i] && q[i].size() > 0) void'(q[i].pop_front());
        end
        if (busy_cnt > 0) busy_cnt--;
        if (start_seen && !stub_dead) rise_in = $urandom_range(0, 3);
        if (rise_in == 0) begin busy_cnt = $urandom_range(1, 12); rise_in = -1; end
        else if (rise_in > 0) rise_in--;
        tx_busy = ext_busy || (busy_cnt > 0);
        drive();
    endtask

    task automatic clear_bench();
        for (int i = 0; i < N; i++) q[i].delete();
        hold = '0; stub_dead = 0; ext_busy = 0; rise_in = -1; busy_cnt = 0; tx_busy = 1'b0;
        drive();
    endtask

    task automatic wait_log(input int n, input int budget, input string name);
        int t = 0;
        while (log_q.size() < n && t < budget) begin tick(); t++; end
        check(name, log_q.size() >= n, 1);
    endtask

    task automatic wait_drain(input int budget);
        int t = 0;
        bit busy_q;
        busy_q = 1;
        while (busy_q && t < budget) begin
            busy_q = m_inflight || tx_busy;
            for (int i = 0; i < N; i++) if (q[i].size() > 0) busy_q = 1;
            tick(); t++;
        end
        check("drain_budget", t < budget, 1);
    endtask

    task automatic expect_bytes(input string name, input logic [7:0] exp[], input int base);
        for (int i = 0; i < exp.size(); i++) begin
            if (base + i < log_q.size()) check(name, log_q[base + i], exp[i]);
            else check(name, 32'hFFFF_FFFF, exp[i]);
        end
    endtask

    initial begin
        logic [7:0] e_rot[], e_hi[], e_drop[];
        int total, a0, t;
        e_rot  = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h30, 8'h31, 8'h32, 8'h33};
        e_hi   = '{8'h48, 8'h49, 8'h0D, 8'h0A, 8'h41};
        e_drop = '{8'h70, 8'h71, 8'h72, 8'h55};
        clear_bench();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("reset_tx_start", tx_start, 0);
        check("reset_locked", locked, 0);
        check("reset_grant", grant_id, 0);
        check("reset_tx_data", tx_data, 0);
        repeat (100) tick();
        check("idle_no_bytes", log_q.size(), 0);

        // All four valid with single-byte packets: strict rotation from requester 0
        log_q.delete();
        for (int rep = 0; rep < 2; rep++)
            for (int i = 0; i < N; i++) push(i, 8'h30 + 8'(i), 1'b1);
        drive();
        wait_log(8, 600, "rot_budget");
        expect_bytes("rot_order", e_rot, 0);
        wait_drain(200);

        // "HI\r\n" packet from req0 holds the UART against req1
        log_q.delete();
        push(0, 8'h48, 1'b0); push(0, 8'h49, 1'b0); push(0, 8'h0D, 1'b0); push(0, 8'h0A, 1'b1);
        push(1, 8'h41, 1'b1);
        drive();
        wait_log(5, 600, "hi_budget");
        expect_bytes("hi_order", e_hi, 0);
        wait_drain(200);

        // Locked owner req2 goes quiet mid-packet; req0 must stall
        log_q.delete();
        push(2, 8'h70, 1'b0); push(2, 8'h71, 1'b0); push(2, 8'h72, 1'b1);
        drive();
        wait_log(1, 200, "drop_first_budget");
        hold[2] = 1'b1;
        push(0, 8'h55, 1'b1);
        drive();
        repeat (40) tick();
        a0 = 0;
        for (int c = 0; c < 1000; c++) begin
            tick();
            if (req_valid[0] && req_ready[0]) a0++;
            if (c % 100 == 0) begin
                check("drop_locked", locked, 1);
                check("drop_grant", grant_id, 2);
            end
        end
        check("drop_req0_accepts", a0, 0);
        hold[2] = 1'b0;
        drive();
        wait_log(4, 600, "drop_rest_budget");
        expect_bytes("drop_order", e_drop, 0);
        wait_drain(200);

        // Transmitter never goes busy: each byte times out 64 cycles after its start
        log_q.delete();
        n_err = 0;
        stub_dead = 1;
        push(3, 8'h7E, 1'b1); push(3, 8'h7F, 1'b1);
        drive();
        t = 0;
        while (n_err < 2 && t < 400) begin tick(); t++; end
        check("timeout_count", n_err, 2);
        check("timeout_gap", gap, 64);
        check("timeout_unlocked", locked, 0);
        stub_dead = 0;
        wait_drain(200);

        // Busy already high from outside: nothing accepted until it falls
        log_q.delete();
        ext_busy = 1;
        tick();
        push(1, 8'h42, 1'b1);
        drive();
        repeat (30) tick();
        check("ext_busy_held", log_q.size(), 0);
        ext_busy = 0;
        wait_log(1, 100, "ext_busy_budget");
        check("ext_busy_byte", log_q.size() > 0 ? log_q[0] : 8'hFF, 8'h42);
        wait_drain(200);

        // Randomized packet mix checked by the model
        log_q.delete();
        total = 0;
        for (int batch = 0; batch < 4; batch++) begin
            for (int p = 0; p < 15; p++) begin
                int r, len;
                r   = $urandom_range(0, N - 1);
                len = $urandom_range(1, 4);
                for (int b = 0; b < len; b++) push(r, 8'($urandom), b == len - 1);
                total += len;
            end
            drive();
            repeat ($urandom_range(0, 50)) tick();
        end
        wait_log(total, 20000, "rand_budget");
        wait_drain(400);
        check("rand_count", log_q.size(), total);

        // Asynchronous reset while a locked packet is on the wire
        log_q.delete();
        push(1, 8'h60, 1'b0); push(1, 8'h61, 1'b0); push(1, 8'h62, 1'b1);
        drive();
        t = 0;
        while (!(m_inflight && m_busy_seen && locked) && t < 400) begin tick(); t++; end
        check("arst_reach_wait_done", t < 400, 1);
        rst_n = 1'b0;
        #1;
        check("arst_tx_start", tx_start, 0);
        check("arst_locked", locked, 0);
        check("arst_ready", req_ready, 0);
        check("arst_grant", grant_id, 0);
        clear_bench();
        repeat (2) tick();
        log_q.delete();
        for (int i = 0; i < N; i++) push(i, 8'hA0 + 8'(i), 1'b1);
        drive();
        rst_n = 1'b1;
        wait_log(1, 50, "arst_first_budget");
        check("arst_first_winner", log_q.size() > 0 ? log_q[0] : 8'hFF, 8'hA0);
        wait_drain(400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
